// File: rtl/pixel_stream_pkg.sv
// Shared pixel-stream definitions: channel/bus widths, byte lanes of the
// packed AXI-Stream word, and the RGB packing helper used on both sides.
package pixel_stream_pkg;

  localparam int DATA_WIDTH         = 8;
  localparam int C_AXIS_TDATA_WIDTH = 32;
  localparam int C_AXIS_TSTRB_WIDTH = C_AXIS_TDATA_WIDTH / 8;

  // Most significant bit of each colour byte inside tdata.
  localparam int R_MSB = 31;
  localparam int G_MSB = 23;
  localparam int B_MSB = 15;

  // {R,G,B,pad}: R in [31:24], G in [23:16], B in [15:8], pad byte zero.
  function automatic logic [C_AXIS_TDATA_WIDTH-1:0] pack_rgb(
    input logic [DATA_WIDTH-1:0] r,
    input logic [DATA_WIDTH-1:0] g,
    input logic [DATA_WIDTH-1:0] b
  );
    return {r, g, b, 8'h00};
  endfunction

endpackage

// File: rtl/output_buffer_if.sv
// AXI-Stream bundle carrying processed pixels out of output_buffer.
// Handshake: a beat transfers on a rising clock edge where tvalid && tready.
// The master holds tdata/tlast stable while tvalid && !tready, and never
// makes tvalid depend on tready; the slave may change tready at any time.
interface output_buffer_if;
  import pixel_stream_pkg::*;

  logic                          tvalid;
  logic                          tready;
  logic [C_AXIS_TDATA_WIDTH-1:0] tdata;
  logic [C_AXIS_TSTRB_WIDTH-1:0] tstrb;
  logic                          tlast;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/output_buffer_token_delay_line.sv
// Enable-gated token shift register. A token entered at din appears at dout
// after DEPTH enabled cycles; contents hold while en is low so the token
// stays aligned with the stalled processing pipeline.
module token_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic any_set
);

  logic [DEPTH-1:0] tok;

  generate
    if (DEPTH == 1) begin : g_one
      // Single stage: load on every enabled cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  tok <= '0;
        else if (en) tok <= din;
      end
    end else begin : g_many
      // Shift toward tok[DEPTH-1]; tok[0] is the newest entry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  tok <= '0;
        else if (en) tok <= {tok[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout    = tok[DEPTH-1];
  assign any_set = |tok;

endmodule

// File: rtl/output_buffer.sv
// Collects processed pixels for each full-column window and emits them as an
// AXI-Stream packet of INPUT_HEIGHT beats, tlast on the final pixel. A token
// delayed by PIPE_LATENCY advances marks where a window's first valid pixel
// arrives; row_cnt then admits the remaining pixels of that window.
module output_buffer
  import pixel_stream_pkg::*;
#(
  parameter int DATA_WIDTH         = pixel_stream_pkg::DATA_WIDTH,
  parameter int C_AXIS_TDATA_WIDTH = pixel_stream_pkg::C_AXIS_TDATA_WIDTH,
  parameter int INPUT_HEIGHT       = 480,
  parameter int PIPE_LATENCY       = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] proc_R,
  input  logic [DATA_WIDTH-1:0] proc_G,
  input  logic [DATA_WIDTH-1:0] proc_B,
  input  logic                  is_full_columns_first_input,
  input  logic                  data_flowing,
  output logic                  output_has_back_pressure,
  output logic                  output_buffer_is_done,
  output logic                  overflow_err,
  output_buffer_if.master       m_axis
);

  localparam int CW = $clog2(INPUT_HEIGHT + 1);

  logic                          tok_out;
  logic                          tok_any;
  logic [CW-1:0]                 row_cnt;
  logic                          row_busy;
  logic                          cap;
  logic                          last_pix;
  logic                          tvalid_q;
  logic                          tlast_q;
  logic [C_AXIS_TDATA_WIDTH-1:0] tdata_q;

  token_delay_line #(.DEPTH(PIPE_LATENCY)) u_tok (
    .clk     (aclk),
    .rst_n   (aresetn),
    .en      (data_flowing),
    .din     (is_full_columns_first_input),
    .dout    (tok_out),
    .any_set (tok_any)
  );

  assign row_busy = (row_cnt != '0);
  assign cap      = data_flowing && (tok_out || row_busy);
  // A new token restarts the window, so its pixel is last only for 1-row windows.
  assign last_pix = tok_out ? (INPUT_HEIGHT == 1) : (row_cnt == CW'(1));

  // Window row counter and sticky error: overlapping tokens or a capture
  // landing on a beat the slave has not yet taken.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      row_cnt      <= '0;
      overflow_err <= 1'b0;
    end else if (cap) begin
      if (tok_out) begin
        row_cnt <= CW'(INPUT_HEIGHT - 1);
        if (row_busy) overflow_err <= 1'b1;
      end else begin
        row_cnt <= row_cnt - CW'(1);
      end
      if (tvalid_q && !m_axis.tready) overflow_err <= 1'b1;
    end
  end

  // Output beat register: load on capture (back-to-back with a drain is
  // allowed), otherwise hold until the slave accepts, then drop tvalid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else if (cap) begin
      tvalid_q <= 1'b1;
      tlast_q  <= last_pix;
      tdata_q  <= pack_rgb(proc_R, proc_G, proc_B);
    end else if (tvalid_q && m_axis.tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tstrb  = '1;

  assign output_has_back_pressure = tvalid_q && !m_axis.tready;
  assign output_buffer_is_done    = !tok_any && !row_busy && !tvalid_q;

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer with INPUT_HEIGHT=4, PIPE_LATENCY=2.
module tb_output_buffer;

  logic       aclk;
  logic       aresetn;
  logic [7:0] proc_R, proc_G, proc_B;
  logic       is_first;
  logic       data_flowing;
  logic       bp, done, err;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  output_buffer_if axis ();

  output_buffer #(
    .INPUT_HEIGHT (4),
    .PIPE_LATENCY (2)
  ) dut (
    .aclk                        (aclk),
    .aresetn                     (aresetn),
    .proc_R                      (proc_R),
    .proc_G                      (proc_G),
    .proc_B                      (proc_B),
    .is_full_columns_first_input (is_first),
    .data_flowing                (data_flowing),
    .output_has_back_pressure    (bp),
    .output_buffer_is_done       (done),
    .overflow_err                (err),
    .m_axis                      (axis)
  );

  // clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // record every accepted beat as {tlast, tdata}; inputs are stable at negedge
  always @(negedge aclk) begin
    if (aresetn && axis.tvalid && axis.tready) got_q.push_back({axis.tlast, axis.tdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] beat(input logic [7:0] r, input logic last);
    logic [7:0] g, b;
    g = r + 8'd16;
    b = r + 8'd32;
    return {last, r, g, b, 8'h00};
  endfunction

  task automatic drive(input logic first, input logic df, input logic [7:0] r, input logic rdy);
    is_first     = first;
    data_flowing = df;
    proc_R       = r;
    proc_G       = r + 8'd16;
    proc_B       = r + 8'd32;
    axis.tready  = rdy;
    @(posedge aclk);
    #1;
  endtask

  task automatic compare_beats(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    drive(1'b0, 1'b1, 8'd0, 1'b1);
    drive(1'b0, 1'b1, 8'd0, 1'b1);
    aresetn = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    got_q.delete();
  endtask

  initial begin
    aresetn = 1'b0;
    is_first = 1'b0; data_flowing = 1'b0;
    proc_R = '0; proc_G = '0; proc_B = '0;
    axis.tready = 1'b1;

    // 1: reset held with data_flowing=1
    aresetn = 1'b0;
    drive(1'b1, 1'b1, 8'd7, 1'b0);
    drive(1'b1, 1'b1, 8'd7, 1'b0);
    chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("rst_done",   64'(done), 64'd1);
    chk("rst_bp",     64'(bp), 64'd0);
    chk("rst_err",    64'(err), 64'd0);
    chk("rst_tdata",  64'(axis.tdata), 64'd0);
    chk("rst_tlast",  64'(axis.tlast), 64'd0);
    chk("rst_tstrb",  64'(axis.tstrb), 64'hF);
    do_reset();

    // 2/5: streaming with tready=1, back-to-back beats
    drive(1'b1, 1'b1, 8'd1, 1'b1);
    chk("s_done_fall", 64'(done), 64'd0);
    drive(1'b0, 1'b1, 8'd2, 1'b1);
    chk("s_lat_tvalid", 64'(axis.tvalid), 64'd0);
    for (int r = 3; r <= 6; r++) begin
      drive(1'b0, 1'b1, 8'(r), 1'b1);
      chk($sformatf("s_tvalid_r%0d", r), 64'(axis.tvalid), 64'd1);
      chk($sformatf("s_tlast_r%0d", r), 64'(axis.tlast), (r == 6) ? 64'd1 : 64'd0);
      exp_q.push_back(beat(8'(r), r == 6));
    end
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    chk("s_tvalid_end", 64'(axis.tvalid), 64'd0);
    chk("s_done_end",   64'(done), 64'd1);
    compare_beats("stream");

    // 3: stall on beat 2 with data_flowing held low while back-pressured
    drive(1'b1, 1'b1, 8'd1, 1'b1);
    drive(1'b0, 1'b1, 8'd2, 1'b1);
    drive(1'b0, 1'b1, 8'd3, 1'b1);
    drive(1'b0, 1'b1, 8'd4, 1'b1);
    axis.tready = 1'b0;
    #1;
    chk("st_bp_on", 64'(bp), 64'd1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 8'd99, 1'b0);
      chk($sformatf("st_hold_data%0d", k), 64'({axis.tvalid, axis.tlast, axis.tdata}),
          64'({1'b1, beat(8'd4, 1'b0)}));
    end
    drive(1'b0, 1'b1, 8'd5, 1'b1);
    chk("st_rel_tvalid5", 64'(axis.tvalid), 64'd1);
    drive(1'b0, 1'b1, 8'd6, 1'b1);
    chk("st_rel_tvalid6", 64'(axis.tvalid), 64'd1);
    chk("st_rel_tlast6",  64'(axis.tlast), 64'd1);
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    chk("st_done", 64'(done), 64'd1);
    chk("st_err",  64'(err), 64'd0);
    exp_q.push_back(beat(8'd3, 1'b0));
    exp_q.push_back(beat(8'd4, 1'b0));
    exp_q.push_back(beat(8'd5, 1'b0));
    exp_q.push_back(beat(8'd6, 1'b1));
    compare_beats("stall");

    // 4: padding, no token
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 8'(k + 40), 1'b1);
      chk($sformatf("pad_done%0d", k), 64'({done, axis.tvalid}), 64'b10);
    end
    compare_beats("pad");

    // 6a: capture while beat pending and not accepted
    drive(1'b1, 1'b1, 8'd1, 1'b0);
    drive(1'b0, 1'b1, 8'd2, 1'b0);
    drive(1'b0, 1'b1, 8'd3, 1'b0);
    chk("ov_err_before", 64'(err), 64'd0);
    drive(1'b0, 1'b1, 8'd4, 1'b0);
    chk("ov_err_set",  64'(err), 64'd1);
    chk("ov_overwrite", 64'({axis.tlast, axis.tdata}), 64'(beat(8'd4, 1'b0)));
    drive(1'b0, 1'b1, 8'd5, 1'b1);
    drive(1'b0, 1'b1, 8'd6, 1'b1);
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    chk("ov_err_sticky", 64'({err, done}), 64'b11);
    exp_q.push_back(beat(8'd4, 1'b0));
    exp_q.push_back(beat(8'd5, 1'b0));
    exp_q.push_back(beat(8'd6, 1'b1));
    compare_beats("ov");
    do_reset();
    chk("ov_err_cleared", 64'(err), 64'd0);

    // 6b: overlapping token sets error, then mid-stream reset drops everything
    drive(1'b1, 1'b1, 8'd1, 1'b1);
    drive(1'b1, 1'b1, 8'd2, 1'b1);
    drive(1'b0, 1'b1, 8'd3, 1'b1);
    chk("olap_err_first", 64'(err), 64'd0);
    drive(1'b0, 1'b1, 8'd4, 1'b1);
    chk("olap_err_set", 64'(err), 64'd1);
    chk("olap_restart_tlast", 64'(axis.tlast), 64'd0);
    drive(1'b0, 1'b1, 8'd5, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_out", 64'({axis.tvalid, done, bp, err}), 64'b0100);
    drive(1'b0, 1'b1, 8'd6, 1'b1);
    aresetn = 1'b1;
    got_q.delete();
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 8'(k + 60), 1'b1);
    chk("mid_rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("mid_rst_done",   64'(done), 64'd1);
    compare_beats("mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
